// File: rtl/banked_sram_sync.sv
// Banked single-port synchronous RAM with registered reads,
// zero-fill sweep after reset, ready/rd_valid strobes and sticky error.
module banked_sram_sync #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 7,
  parameter int BANK_BITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_W-1:0]             adrs,
  input  logic [DATA_W-1:0]             dataIn,
  output logic [DATA_W-1:0]             dataOut,
  input  logic                          _ce,
  input  logic                          _we,
  input  logic                          _oe,
  output logic                          ready,
  output logic                          rd_valid,
  output logic [(1<<BANK_BITS)-1:0]     _bce,
  output logic                          acc_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NBANK = 1 << BANK_BITS;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [DATA_W-1:0]   dout_q;
  logic                rdv_q;
  logic [NBANK-1:0]    bce_q;
  logic                err_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr;
  logic                rd;
  logic [BANK_BITS-1:0] bank;
  logic [NBANK-1:0]    bce_d;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_a;
  logic [DATA_W-1:0]   mem_wd;

  // Write wins when _we and _oe are both asserted.
  assign wr    = ~_ce & ~_we;
  assign rd    = ~_ce &  _we & ~_oe;
  assign bank  = adrs[ADDR_W-1 -: BANK_BITS];
  assign bce_d = ~(NBANK'(1) << bank);

  always_comb begin
    mem_we = 1'b0;
    mem_a  = adrs;
    mem_wd = dataIn;
    if (state_q == INIT) begin
      mem_we = 1'b1;
      mem_a  = cnt_q;
      mem_wd = '0;
    end else if (wr) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      dout_q  <= '0;
      rdv_q   <= 1'b0;
      bce_q   <= '1;
      err_q   <= 1'b0;
    end else begin
      rdv_q <= 1'b0;
      bce_q <= '1;
      unique case (state_q)
        INIT: begin
          cnt_q <= cnt_q + ADDR_W'(1);
          if (cnt_q == '1) state_q <= RUN;
          if (wr | rd) err_q <= 1'b1;
        end
        RUN: begin
          if (wr | rd) bce_q <= bce_d;
          if (rd) begin
            dout_q <= mem[adrs];
            rdv_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign ready    = (state_q == RUN);
  assign dataOut  = dout_q;
  assign rd_valid = rdv_q;
  assign _bce     = bce_q;
  assign acc_err  = err_q;

endmodule

// File: tb/tb_banked_sram_sync.sv
// Directed self-checking bench for banked_sram_sync.
// Inputs change on negedge; outputs sampled 1ns after posedge.
module tb_banked_sram_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] adrs;
  logic [7:0] dataIn;
  logic [7:0] dataOut;
  logic       _ce, _we, _oe;
  logic       ready;
  logic       rd_valid;
  logic [7:0] _bce;
  logic       acc_err;

  int checks = 0;
  int errors = 0;

  banked_sram_sync #(.DATA_W(8), .ADDR_W(7), .BANK_BITS(3)) dut (
    .clk(clk), .rst(rst), .adrs(adrs), .dataIn(dataIn),
    .dataOut(dataOut), ._ce(_ce), ._we(_we), ._oe(_oe),
    .ready(ready), .rd_valid(rd_valid), ._bce(_bce),
    .acc_err(acc_err)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic ce, input logic we,
                     input logic oe, input logic [6:0] a,
                     input logic [7:0] d);
    @(negedge clk);
    _ce = ce; _we = we; _oe = oe; adrs = a; dataIn = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b1, 1'b1, 1'b1, 7'h00, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    _ce = 1'b1; _we = 1'b1; _oe = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Releases reset at a negedge and counts edges until ready.
  task automatic release_and_wait(output int n, output int bad);
    n = 0;
    bad = 0;
    rst = 1'b0;
    while (n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (ready === 1'b1) break;
      if (_bce !== 8'hFF || rd_valid !== 1'b0) bad++;
    end
  endtask

  task automatic test_reset();
    int n, bad;
    do_reset();
    checks++;
    if (dataOut !== 8'h00 || rd_valid !== 1'b0 || ready !== 1'b0 ||
        _bce !== 8'hFF || acc_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: dout=%h rdv=%b rdy=%b bce=%h err=%b exp 00 0 0 FF 0",
               dataOut, rd_valid, ready, _bce, acc_err);
    end
    release_and_wait(n, bad);
    checks++;
    if (n != 128) begin
      errors++;
      $display("FAIL ready_latency: got %0d exp 128", n);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL init_outputs: %0d bad cycles exp 0", bad);
    end
    cyc(1'b0, 1'b1, 1'b0, 7'h55, 8'h00);
    checks++;
    if (dataOut !== 8'h00 || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_read: dout=%h rdv=%b exp 00 1", dataOut, rd_valid);
    end
    idle();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rdv_pulse: rdv=%b exp 0", rd_valid);
    end
  endtask

  task automatic test_burst();
    logic [6:0] a [3];
    logic [7:0] d [3];
    logic [7:0] b [3];
    a = '{7'h00, 7'h10, 7'h7F};
    d = '{8'hA5, 8'h3C, 8'hFF};
    b = '{8'hFE, 8'hFD, 8'h7F};
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, a[i], d[i]);
      checks++;
      if (_bce !== b[i] || rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL wr_bce[%0d]: bce=%h rdv=%b exp %h 0",
                 i, _bce, rd_valid, b[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, a[i], 8'h00);
      checks++;
      if (dataOut !== d[i] || rd_valid !== 1'b1 || _bce !== b[i]) begin
        errors++;
        $display("FAIL rd_burst[%0d]: dout=%h rdv=%b bce=%h exp %h 1 %h",
                 i, dataOut, rd_valid, _bce, d[i], b[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    cyc(1'b0, 1'b0, 1'b1, 7'h22, 8'h11);
    cyc(1'b0, 1'b1, 1'b0, 7'h22, 8'h00);
    checks++;
    if (dataOut !== 8'h11 || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL raw: dout=%h rdv=%b exp 11 1", dataOut, rd_valid);
    end
    cyc(1'b0, 1'b0, 1'b0, 7'h22, 8'h99);
    checks++;
    if (rd_valid !== 1'b0 || _bce !== 8'hFB || dataOut !== 8'h11) begin
      errors++;
      $display("FAIL we_oe_conflict: rdv=%b bce=%h dout=%h exp 0 FB 11",
               rd_valid, _bce, dataOut);
    end
    cyc(1'b0, 1'b1, 1'b0, 7'h22, 8'h00);
    checks++;
    if (dataOut !== 8'h99 || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL conflict_read: dout=%h rdv=%b exp 99 1", dataOut, rd_valid);
    end
  endtask

  task automatic test_idle();
    int bad = 0;
    cyc(1'b0, 1'b1, 1'b0, 7'h10, 8'h00);
    checks++;
    if (dataOut !== 8'h3C) begin
      errors++;
      $display("FAIL idle_pre_read: dout=%h exp 3C", dataOut);
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 7'h22, 8'h5A);
      if (dataOut !== 8'h3C || rd_valid !== 1'b0 || _bce !== 8'hFF) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_hold: %0d bad cycles exp 0", bad);
    end
    cyc(1'b0, 1'b1, 1'b0, 7'h22, 8'h00);
    checks++;
    if (dataOut !== 8'h99) begin
      errors++;
      $display("FAIL idle_no_write: dout=%h exp 99", dataOut);
    end
  endtask

  task automatic test_init_err();
    int n, bad;
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) idle();
    cyc(1'b0, 1'b0, 1'b1, 7'h05, 8'h77);
    checks++;
    if (acc_err !== 1'b1 || _bce !== 8'hFF) begin
      errors++;
      $display("FAIL acc_err_set: err=%b bce=%h exp 1 FF", acc_err, _bce);
    end
    n = 0;
    while (ready !== 1'b1 && n < 400) begin
      idle();
      n++;
    end
    checks++;
    if (ready !== 1'b1 || acc_err !== 1'b1) begin
      errors++;
      $display("FAIL acc_err_sticky: rdy=%b err=%b exp 1 1", ready, acc_err);
    end
    cyc(1'b0, 1'b1, 1'b0, 7'h05, 8'h00);
    checks++;
    if (dataOut !== 8'h00 || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL init_write_ignored: dout=%h rdv=%b exp 00 1",
               dataOut, rd_valid);
    end
  endtask

  task automatic test_reset_mid_init();
    int n, bad;
    cyc(1'b0, 1'b0, 1'b1, 7'h40, 8'hEE);
    cyc(1'b0, 1'b1, 1'b0, 7'h40, 8'h00);
    checks++;
    if (dataOut !== 8'hEE) begin
      errors++;
      $display("FAIL pre_reset_write: dout=%h exp EE", dataOut);
    end
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) idle();
    do_reset();
    release_and_wait(n, bad);
    checks++;
    if (n != 128 || bad != 0) begin
      errors++;
      $display("FAIL second_ready: lat=%0d bad=%0d exp 128 0", n, bad);
    end
    cyc(1'b0, 1'b1, 1'b0, 7'h40, 8'h00);
    checks++;
    if (dataOut !== 8'h00 || acc_err !== 1'b0 || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL recleared: dout=%h err=%b rdv=%b exp 00 0 1",
               dataOut, acc_err, rd_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    _ce = 1'b1; _we = 1'b1; _oe = 1'b1;
    adrs = '0; dataIn = '0;
    test_reset();
    test_burst();
    test_back_to_back();
    test_idle();
    test_init_err();
    test_reset_mid_init();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
